// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..NB_DATA data bits, none/even/odd parity, 1 or 2 stop bits.
// Frame configuration and payload are captured when a frame is accepted, so later changes never disturb it.
module uart_tx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int NB_TICK    = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [3:0]         i_cfg_dbits,
  input  logic [1:0]         i_cfg_parity,
  input  logic               i_cfg_stop2,
  output logic               o_tx,
  output logic               o_ready,
  output logic               o_tx_done_tick
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(OVERSAMPLE - 1);
  localparam logic [3:0]         DBITS_MIN = 4'd5;
  localparam logic [3:0]         DBITS_MAX = 4'(NB_DATA);

  logic [2:0]         state_reg, state_next;
  logic [NB_TICK-1:0] tick_reg, tick_next;
  logic [3:0]         bit_reg, bit_next;
  logic               stop_cnt_reg, stop_cnt_next;
  logic [NB_DATA-1:0] shift_reg, shift_next;
  logic [3:0]         dbits_reg, dbits_next;
  logic               par_en_reg, par_en_next;
  logic               par_bit_reg, par_bit_next;
  logic               stop2_reg, stop2_next;
  logic               tx_reg, tx_next;
  logic               done_reg, done_next;

  logic [3:0]         dbits_clamp;
  logic [NB_DATA-1:0] data_masked;
  logic               tick_last;

  assign dbits_clamp = (i_cfg_dbits < DBITS_MIN) ? DBITS_MIN :
                       (i_cfg_dbits > DBITS_MAX) ? DBITS_MAX : i_cfg_dbits;

  // Only the configured data bits take part in the parity calculation.
  generate
    for (genvar gi = 0; gi < NB_DATA; gi++) begin : g_mask
      localparam logic [3:0] IDX = 4'(gi);
      assign data_masked[gi] = i_data[gi] & (IDX < dbits_clamp);
    end
  endgenerate

  assign tick_last = i_s_tick && (tick_reg == TICK_LAST);

  always_comb begin
    state_next    = state_reg;
    tick_next     = tick_reg;
    bit_next      = bit_reg;
    stop_cnt_next = stop_cnt_reg;
    shift_next    = shift_reg;
    dbits_next    = dbits_reg;
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
    stop2_next    = stop2_reg;
    done_next     = 1'b0;

    if (state_reg != ST_IDLE && i_s_tick)
      tick_next = tick_last ? '0 : tick_reg + NB_TICK'(1);

    case (state_reg)
      ST_IDLE: begin
        if (i_tx_start) begin
          state_next    = ST_START;
          tick_next     = '0;
          bit_next      = '0;
          stop_cnt_next = 1'b0;
          shift_next    = i_data;
          dbits_next    = dbits_clamp;
          par_en_next   = i_cfg_parity[0] ^ i_cfg_parity[1];
          par_bit_next  = (^data_masked) ^ (i_cfg_parity == 2'b10);
          stop2_next    = i_cfg_stop2;
        end
      end
      ST_START: begin
        if (tick_last) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (tick_last) begin
          if (bit_reg == dbits_reg - 4'd1) begin
            state_next    = par_en_reg ? ST_PARITY : ST_STOP;
            stop_cnt_next = 1'b0;
          end else begin
            shift_next = shift_reg >> 1;
            bit_next   = bit_reg + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick_last) begin
          state_next    = ST_STOP;
          stop_cnt_next = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick_last) begin
          if (stop2_reg && !stop_cnt_reg) begin
            stop_cnt_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The line level is derived from the next state so o_tx is a clean register output.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_bit_next;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      tick_reg     <= '0;
      bit_reg      <= '0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
      dbits_reg    <= DBITS_MIN;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_reg     <= tick_next;
      bit_reg      <= bit_next;
      stop_cnt_reg <= stop_cnt_next;
      shift_reg    <= shift_next;
      dbits_reg    <= dbits_next;
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
      stop2_reg    <= stop2_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
    end
  end

  assign o_tx           = tx_reg;
  assign o_ready        = (state_reg == ST_IDLE);
  assign o_tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: checks line level at the first and last cycle of every bit,
// ready/done timing, ignored mid-frame starts, back-to-back frames and asynchronous reset.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] data;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx;
  logic       ready;
  logic       done;

  int total = 0;
  int bad   = 0;
  int tick_div = 1;
  int tick_cnt = 0;

  uart_tx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .NB_TICK(4)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_s_tick       (s_tick),
    .i_tx_start     (tx_start),
    .i_data         (data),
    .i_cfg_dbits    (cfg_dbits),
    .i_cfg_parity   (cfg_parity),
    .i_cfg_stop2    (cfg_stop2),
    .o_tx           (tx),
    .o_ready        (ready),
    .o_tx_done_tick (done)
  );

  always #5 clk = ~clk;

  // Tick generator: one pulse every tick_div cycles, updated on the falling edge.
  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      s_tick   = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick   = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raise start in a cycle whose rising edge also carries a tick, so that tick is the uncounted one.
  task automatic accept();
    int guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (!s_tick && guard < 100);
    chk("tick_align", {31'b0, s_tick}, 32'd1);
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  // Entered one step after the accepting edge. bits[k] is the k-th 16-tick unit on the line.
  // mode[0]: mid-frame start with new data/config; mode[1]: hold start during the done pulse.
  task automatic observe(input string tag, input logic [15:0] bits, input int nbits,
                         input int div, input int mode);
    int bc  = 16 * div;
    int len = bc * nbits;
    for (int c = 0; c < len; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c % bc == 0 || c % bc == bc - 1)
        chk({tag, "_tx"}, {31'b0, tx}, {31'b0, bits[c / bc]});
      if (c == 0 || c == len - 1) begin
        chk({tag, "_busy"}, {31'b0, ready}, 32'd0);
        chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
      end
      if (mode[0] && c == 30) begin
        data = 8'h00; cfg_dbits = 4'd8; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        tx_start = 1'b1;
      end
      if (mode[0] && c == 31) tx_start = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
    chk({tag, "_idle_tx"}, {31'b0, tx}, 32'd1);
    if (mode[1]) begin
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      chk({tag, "_chain_tx"}, {31'b0, tx}, 32'd0);
      chk({tag, "_chain_busy"}, {31'b0, ready}, 32'd0);
      chk({tag, "_chain_nodone"}, {31'b0, done}, 32'd0);
    end else begin
      @(posedge clk); #1;
      chk({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
    end
    $display("frame %s: %0d units of %0d cycles checked, bad so far=%0d", tag, nbits, bc, bad);
  endtask

  task automatic set_cfg(input logic [7:0] d, input logic [3:0] db, input logic [1:0] par,
                         input logic st2, input int div);
    data = d; cfg_dbits = db; cfg_parity = par; cfg_stop2 = st2;
    tick_div = div;
  endtask

  initial begin
    rst = 1'b1; tx_start = 1'b0; s_tick = 1'b0;
    set_cfg(8'h00, 4'd8, 2'b00, 1'b0, 1);
    #1;
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_tx", {31'b0, tx}, 32'd1);

    // 8N1 0xA5: 0, 1,0,1,0,0,1,0,1, 1
    set_cfg(8'hA5, 4'd8, 2'b00, 1'b0, 1);
    accept();
    observe("8n1_a5", 16'b1101001010, 10, 1, 0);

    // 7E1 0x03: 0, 1,1,0,0,0,0,0, parity 0, 1
    set_cfg(8'h03, 4'd7, 2'b01, 1'b0, 1);
    accept();
    observe("7e1_03", 16'b1000000110, 10, 1, 0);

    // 7O1 0x03: parity 1
    set_cfg(8'h03, 4'd7, 2'b10, 1'b0, 1);
    accept();
    observe("7o1_03", 16'b1100000110, 10, 1, 0);

    // dbits=3 clamps to 5, two stop bits: 0, 1,1,1,1,1, 1,1
    set_cfg(8'hFF, 4'd3, 2'b00, 1'b1, 1);
    accept();
    observe("5n2_ff", 16'b11111110, 8, 1, 0);

    // 8N1 0x3C with an ignored mid-frame start (0x00, 8O2), then chained frame uses 0x00 8O2
    set_cfg(8'h3C, 4'd8, 2'b00, 1'b0, 1);
    accept();
    observe("8n1_3c", 16'b1001111000, 10, 1, 3);
    // 8O2 0x00: 0, 0 x8, parity 1, 1, 1
    observe("8o2_00", 16'b111000000000, 12, 1, 0);

    // Reset in the middle of data bit 3 (0xA5 bit3 = 0)
    set_cfg(8'hA5, 4'd8, 2'b00, 1'b0, 1);
    accept();
    repeat (72) @(posedge clk);
    #1;
    chk("pre_rst_tx", {31'b0, tx}, 32'd0);
    chk("pre_rst_busy", {31'b0, ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", {31'b0, tx}, 32'd1);
    chk("async_rst_ready", {31'b0, ready}, 32'd1);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_done", {31'b0, done}, 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i % 10 == 0) begin
        chk("post_rst_tx", {31'b0, tx}, 32'd1);
        chk("post_rst_nodone", {31'b0, done}, 32'd0);
      end
    end

    // Tick every 5 cycles, 8N1 0x55: each bit 80 cycles
    set_cfg(8'h55, 4'd8, 2'b00, 1'b0, 5);
    accept();
    observe("8n1_55_div5", 16'b1010101010, 10, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter. It is the successor of the fixed 8N1 transmitter and supports programmable data length (5..NB_DATA), none/even/odd parity, and 1 or 2 stop bits. It is driven by the shared baud-rate generator tick (i_s_tick, OVERSAMPLE ticks per bit). It sits between the TX FIFO/interface logic and the serial pin. Frame configuration is captured at frame start, so software may change it mid-frame without corrupting the current frame.

Parameters:
NB_DATA, 8, maximum data bits per frame and width of i_data (must be >= 5)
OVERSAMPLE, 16, i_s_tick pulses per serial bit (must be >= 2)
NB_TICK, 4, tick counter width; must satisfy 2^NB_TICK >= 2*OVERSAMPLE is NOT required (a stop-bit counter handles 2 stop bits); requirement is 2^NB_TICK >= OVERSAMPLE

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_s_tick  in  1  oversample tick, one-cycle pulse from baud generator
i_tx_start  in  1  request to send i_data; honoured only when o_ready=1
i_data  in  NB_DATA  payload, LSB transmitted first; bits above configured length ignored
i_cfg_dbits  in  4  data length 5..NB_DATA, sampled at start
i_cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none; sampled at start
i_cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits; sampled at start
o_tx  out  1  serial line, registered, idle high
o_ready  out  1  high in IDLE, transmitter can accept i_tx_start
o_tx_done_tick  out  1  registered one-cycle pulse when the frame completes

Behaviour:
- Reset (async, any state, mid-frame included):
  - state=IDLE, counters and shift register cleared.
  - o_tx=1, o_ready=1, o_tx_done_tick=0, all immediately.
  - The aborted frame is not resumed.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx=1, o_ready=1.
  - On i_tx_start=1 the block latches i_data, cfg dbits/parity/stop2 and parity bit, clears tick and bit counters, and goes to START.
  - o_tx goes 0 at that same clock edge, i.e. one cycle after the start is sampled. o_ready drops at that edge too.
- Ticks: each bit lasts exactly OVERSAMPLE i_s_tick pulses counted in the bit's state. A tick coincident with the accepting i_tx_start is not counted.
- START: o_tx=0. After OVERSAMPLE ticks, go to DATA with bit index 0.
- DATA:
  - o_tx = shift[0]. Every OVERSAMPLE ticks, shift right and increment the index.
  - After the last configured bit (index = dbits-1), go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Bit = XOR of the configured data bits only, inverted for odd (even: total ones incl. parity even; odd: odd).
  - Lasts OVERSAMPLE ticks, then STOP.
- STOP:
  - o_tx=1 for OVERSAMPLE ticks (stop2=0) or 2*OVERSAMPLE ticks (stop2=1), using a stop-bit counter.
  - On the final tick, go to IDLE.
  - o_tx_done_tick=1 for exactly one cycle, coincident with the first IDLE cycle (o_ready=1).
  - An i_tx_start during that cycle is accepted, giving back-to-back frames with no idle gap beyond one clock.
- i_cfg_dbits < 5 is treated as 5; > NB_DATA is treated as NB_DATA. The clamp is applied at latch time.
- i_tx_start while o_ready=0 is ignored: no re-latch, no queueing.
- Config and i_data changes after acceptance do not affect the frame in progress.
- i_s_tick has no effect in IDLE. Counters do not advance without ticks, so the line holds its current bit indefinitely.
- Frame length in ticks = OVERSAMPLE*(1 + dbits + parity_en + 1 + stop2).

Test Plan:
- 8N1, data 0xA5, OVERSAMPLE=16, tick every cycle -> o_tx: 0, 1,0,1,0,0,1,0,1, 1. Each bit 16 cycles. Done pulse 160 cycles after o_tx falls. o_ready low throughout.
- 7E1, data 0x03 -> 7 data bits 1,1,0,0,0,0,0, parity 0, stop 1. Frame = 160 ticks. 7O1 same data -> parity 1.
- 5N2, data 0xFF, cfg_dbits=3 -> clamped to 5: 0,1,1,1,1,1, then stop high 32 ticks. Done after 128 ticks total.
- Start asserted again mid-frame with data 0x00 and cfg changed to 8O2 -> ignored. Current frame finishes unchanged. Start held during done pulse -> next frame's start bit begins on the next edge.
- Async reset asserted halfway through DATA bit 3 (o_tx=0) -> o_tx=1, o_ready=1 without a clock edge. No done pulse. A next start transmits cleanly.
- Tick every 5 cycles, 8N1, 0x55 -> each bit exactly 80 cycles. A tick coincident with start is not counted.
